// File: rtl/axi_pkg.sv
// Shared AXI3 constants and types used by both ends of the CPU-side AXI link.
// No logic: constants and typedefs only.
package axi_pkg;
  localparam int ID_W = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [7:0] LEN_SINGLE  = 8'd0;

  typedef logic [ID_W-1:0] axi_id_t;
endpackage

// File: rtl/bwe_ram_1r1w.sv
// Word-addressed 32-bit RAM, one synchronous read port and one byte-enabled write port.
// Read data appears the cycle after rd_en; a same-edge read and write to one word returns the old data.
module bwe_ram_1r1w #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic [3:0]        wr_be
);
  logic [31:0] mem [0:(1<<ADDR_W)-1];

  // Array contents are deliberately never reset so they survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end
endmodule

// File: rtl/axi_sram_slave.sv
// Single-beat AXI3 responder backed by an on-chip RAM; independent read FSM and write collector.
// Read latency RD_LAT+1 cycles from AR to rvalid; B response the cycle after the later of AW/W.
module axi_sram_slave #(
  parameter int ADDR_W = 14,
  parameter int RD_LAT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);
  import axi_pkg::*;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

  localparam logic [3:0] RD_LAT_C = RD_LAT[3:0];

  // Read channel
  r_state_t          r_state;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_idx;
  axi_id_t           rid_q;
  logic              arready_q;
  logic              rvalid_q;
  logic              ar_hs;
  logic              rd_en;
  logic [ADDR_W-1:0] ar_idx;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       ram_rd_data;

  assign ar_idx  = araddr[ADDR_W+1:2];
  assign ar_hs   = arvalid & arready_q;
  // With zero latency the RAM is sampled directly off the AR handshake.
  assign rd_en   = (ar_hs && (RD_LAT_C == 4'd0)) || ((r_state == R_WAIT) && (r_cnt == 4'd1));
  assign rd_addr = (r_state == R_IDLE) ? ar_idx : r_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= R_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      rid_q     <= '0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            rid_q     <= arid;
            r_idx     <= ar_idx;
            r_cnt     <= RD_LAT_C;
            arready_q <= 1'b0;
            if (RD_LAT_C == 4'd0) begin
              r_state  <= R_RESP;
              rvalid_q <= 1'b1;
            end else begin
              r_state <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state  <= R_RESP;
            rvalid_q <= 1'b1;
          end
        end
        R_RESP: begin
          if (rready) begin
            r_state   <= R_IDLE;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
          end
        end
        default: begin
          r_state   <= R_IDLE;
          rvalid_q  <= 1'b0;
          arready_q <= 1'b1;
        end
      endcase
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rid     = rid_q;
  assign rdata   = ram_rd_data;
  assign rresp   = RESP_OKAY;
  assign rlast   = 1'b1;

  // Write channel
  logic              aw_have;
  logic              w_have;
  logic              b_pend;
  logic [ADDR_W-1:0] aw_idx_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  axi_id_t           bid_q;
  logic              aw_hs;
  logic              w_hs;
  logic              commit;
  logic [ADDR_W-1:0] wr_idx;
  logic [31:0]       wr_data;
  logic [3:0]        wr_be;

  assign awready = ~aw_have & ~b_pend;
  assign wready  = ~w_have & ~b_pend;
  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid & wready;
  // A handshake landing this cycle counts as captured, so the write lands on the same edge.
  assign commit  = (aw_have | aw_hs) & (w_have | w_hs);
  assign wr_idx  = aw_have ? aw_idx_q : awaddr[ADDR_W+1:2];
  assign wr_data = w_have ? wdata_q : wdata;
  assign wr_be   = w_have ? wstrb_q : wstrb;

  always_ff @(posedge clk) begin
    if (reset) begin
      aw_have  <= 1'b0;
      w_have   <= 1'b0;
      b_pend   <= 1'b0;
      aw_idx_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bid_q    <= '0;
    end else begin
      if (aw_hs) begin
        aw_idx_q <= awaddr[ADDR_W+1:2];
        bid_q    <= awid;
      end
      if (w_hs) begin
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      if (commit) begin
        aw_have <= 1'b0;
        w_have  <= 1'b0;
        b_pend  <= 1'b1;
      end else begin
        aw_have <= aw_have | aw_hs;
        w_have  <= w_have | w_hs;
        if (bready) b_pend <= 1'b0;
      end
    end
  end

  assign bvalid = b_pend;
  assign bid    = bid_q;
  assign bresp  = RESP_OKAY;

  bwe_ram_1r1w #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .reset   (reset),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (ram_rd_data),
    .we      (commit),
    .wr_addr (wr_idx),
    .wr_data (wr_data),
    .wr_be   (wr_be)
  );

  logic unused_ok;
  assign unused_ok = ^{arlen, arsize, arburst, arlock, arcache, arprot,
                       awlen, awsize, awburst, awlock, awcache, awprot,
                       wid, wlast, araddr[31:ADDR_W+2], araddr[1:0],
                       awaddr[31:ADDR_W+2], awaddr[1:0]};
endmodule
